// File: rtl/tdm_mux_pkg.sv
// Shared definitions for the N:1 time-division multiplexer: select-width helper
// and mode encoding.
package tdm_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  // Channel-index width; a 1-bit index is kept even for degenerate N.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_mux_next_chan.sv
// Combinational circular search for the first enabled channel at or after ptr.
// With an all-ones mask this reduces to picked = ptr, found = 1.
module tdm_mux_next_chan #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [SELW-1:0] ptr,
  input  logic [N-1:0]    mask,
  output logic [SELW-1:0] picked,
  output logic            found
);

  localparam logic [SELW:0] N_EXT = (SELW+1)'(N);

  logic [SELW-1:0] cand [N];
  logic [N-1:0]    hit;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [SELW:0] raw_sum;
      // ptr is always < N, so a single subtraction wraps the offset.
      assign raw_sum   = {1'b0, ptr} + (SELW+1)'(gi);
      assign cand[gi]  = (raw_sum >= N_EXT) ? SELW'(raw_sum - N_EXT) : raw_sum[SELW-1:0];
      assign hit[gi]   = mask[cand[gi]];
    end
  endgenerate

  // Walk offsets from far to near so the nearest enabled channel wins.
  always_comb begin
    picked = '0;
    found  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (hit[i]) begin
        picked = cand[i];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_mux_nto1.sv
// N:1 multiplexer with registered valid/ready output, manual or round-robin scan.
// Optional per-channel enable mask when TDM_MUX_CHAN_MASK_EN is defined.
module tdm_mux_nto1
  import tdm_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               auto_en,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef TDM_MUX_CHAN_MASK_EN
  input  logic [N-1:0]       chan_mask,
`endif
  output logic               sel_err
);

  localparam int              NPOW = 1 << SELW;
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  logic [WIDTH-1:0] out_data_reg;
  logic [SELW-1:0]  out_chan_reg;
  logic             out_valid_reg;
  logic             sel_err_reg;
  logic [SELW-1:0]  ptr_reg;

  logic [SELW-1:0]  ptr_next;
  logic [WIDTH-1:0] data_next;
  logic [SELW-1:0]  pick_chan;
  logic             pick_ok;
  logic             have_sample;
  logic             load;

  logic [N-1:0]     mask_eff;
  logic [NPOW-1:0]  mask_ext;
  logic [WIDTH-1:0] chan_data [NPOW];
  logic [SELW-1:0]  picked;
  logic             found;

`ifdef TDM_MUX_CHAN_MASK_EN
  assign mask_eff = chan_mask;
`else
  assign mask_eff = '1;
`endif

  // Pad the channel table to the full index range so out-of-range selects read as disabled/zero.
  genvar gi;
  generate
    for (gi = 0; gi < NPOW; gi++) begin : g_chan
      if (gi < N) begin : g_real
        assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
        assign mask_ext[gi]  = mask_eff[gi];
      end else begin : g_pad
        assign chan_data[gi] = '0;
        assign mask_ext[gi]  = 1'b0;
      end
    end
  endgenerate

  tdm_mux_next_chan #(
    .N    (N),
    .SELW (SELW)
  ) u_next_chan (
    .ptr    (ptr_reg),
    .mask   (mask_eff),
    .picked (picked),
    .found  (found)
  );

  always_comb begin
    load = !out_valid_reg || out_ready;
    if (auto_en == MODE_AUTO) begin
      pick_chan   = picked;
      pick_ok     = found;
      have_sample = found;
      ptr_next    = (picked == LAST) ? '0 : picked + SELW'(1);
    end else begin
      pick_chan   = sel;
      pick_ok     = mask_ext[sel];
      have_sample = 1'b1;
      ptr_next    = ptr_reg;
    end
    data_next = pick_ok ? chan_data[pick_chan] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_valid_reg <= 1'b0;
      sel_err_reg   <= 1'b0;
      ptr_reg       <= '0;
    end else if (load) begin
      if (have_sample) begin
        out_data_reg  <= data_next;
        out_chan_reg  <= pick_chan;
        out_valid_reg <= 1'b1;
        ptr_reg       <= ptr_next;
        if (!pick_ok) sel_err_reg <= 1'b1;
      end else begin
        // Nothing enabled to scan: drain the accepted sample and leave a bubble.
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;
  assign out_valid = out_valid_reg;
  assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_tdm_mux_nto1.sv
// Randomized and directed bench for tdm_mux_nto1 (N=4 main instance, N=3 instance for
// out-of-range select), checked against an integer-level model of the mux behaviour.
module tb_tdm_mux_nto1;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N*W-1:0] in_data;
  logic [1:0]    sel;
  logic          auto_en;
  logic          out_ready;
  logic [3:0]    chan_mask;
  logic [W-1:0]  out_data;
  logic [1:0]    out_chan;
  logic          out_valid;
  logic          sel_err;

  logic [23:0]   in_data3;
  logic [1:0]    sel3;
  logic [W-1:0]  out_data3;
  logic [1:0]    out_chan3;
  logic          out_valid3;
  logic          sel_err3;

  tdm_mux_nto1 #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .sel       (sel),
    .auto_en   (auto_en),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef TDM_MUX_CHAN_MASK_EN
    .chan_mask (chan_mask),
`endif
    .sel_err   (sel_err)
  );

  tdm_mux_nto1 #(.N(3), .WIDTH(W)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data3),
    .sel       (sel3),
    .auto_en   (1'b0),
    .out_data  (out_data3),
    .out_chan  (out_chan3),
    .out_valid (out_valid3),
    .out_ready (1'b1),
`ifdef TDM_MUX_CHAN_MASK_EN
    .chan_mask (3'b111),
`endif
    .sel_err   (sel_err3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state for the N=4 instance
  int         m_ptr   = 0;
  int         m_chan  = 0;
  logic [7:0] m_data  = '0;
  bit         m_valid = 0;
  bit         m_err   = 0;

  function automatic logic [11:0] m_pack();
    logic [1:0] c;
    c = 2'(m_chan);
    return {m_valid, c, m_data, m_err};
  endfunction

  function automatic logic [11:0] d_pack();
    return {out_valid, out_chan, out_data, sel_err};
  endfunction

  function automatic logic [11:0] d3_pack();
    return {out_valid3, out_chan3, out_data3, sel_err3};
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_clock();
    int c;
    bit fnd;
    if (rst) begin
      m_ptr = 0; m_chan = 0; m_data = '0; m_valid = 0; m_err = 0;
      return;
    end
    if (m_valid && !out_ready) return;
    if (auto_en) begin
      fnd = 0;
      c   = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (chan_mask[c]) begin
          fnd = 1;
          break;
        end
      end
      if (fnd) begin
        m_data  = in_data[c*W +: W];
        m_chan  = c;
        m_valid = 1;
        m_ptr   = (c + 1) % N;
      end else begin
        m_valid = 0;
      end
    end else begin
      m_chan  = int'(sel);
      m_valid = 1;
      if (m_chan < N && chan_mask[m_chan]) begin
        m_data = in_data[m_chan*W +: W];
      end else begin
        m_data = '0;
        m_err  = 1;
      end
    end
  endfunction

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] want;
    rst = 0; auto_en = 1; out_ready = 1; in_data = 32'h44332211;
    repeat (3) tick();
    rst = 1;
    tick();
    tick();
    want = '0;
    n_checks++;
    if (d_pack() !== want) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", d_pack(), want);
    end
    n_checks++;
    if (d3_pack() !== want) begin
      n_fail++;
      $display("FAIL reset_state_n3: got %h expected %h", d3_pack(), want);
    end
    rst = 0;
    tick();
    want = {1'b1, 2'd0, 8'h11, 1'b0};
    n_checks++;
    if (d_pack() !== want) begin
      n_fail++;
      $display("FAIL reset_scan_restart: got %h expected %h", d_pack(), want);
    end
  endtask

  task automatic test_manual();
    logic [11:0] want;
    auto_en = 0; out_ready = 1; in_data = 32'h44332211;
    sel = 2'd2;
    tick();
    want = {1'b1, 2'd2, 8'h33, 1'b0};
    n_checks++;
    if (d_pack() !== want) begin
      n_fail++;
      $display("FAIL manual_sel2: got %h expected %h", d_pack(), want);
    end
    sel = 2'd0;
    tick();
    want = {1'b1, 2'd0, 8'h11, 1'b0};
    n_checks++;
    if (d_pack() !== want) begin
      n_fail++;
      $display("FAIL manual_sel0: got %h expected %h", d_pack(), want);
    end
    for (int i = 0; i < 24; i++) begin
      sel       = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      tick();
      n_checks++;
      if (d_pack() !== m_pack()) begin
        n_fail++;
        $display("FAIL manual_random[%0d]: got %h expected %h", i, d_pack(), m_pack());
      end
    end
  endtask

  task automatic test_auto();
    logic [11:0] want;
    logic [1:0]  c;
    logic [7:0]  d;
    in_data = 32'h44332211; out_ready = 1;
    rst = 1;
    tick();
    rst = 0; auto_en = 1; sel = 2'd3;
    for (int i = 0; i < 6; i++) begin
      tick();
      c    = 2'(i % 4);
      d    = 8'(8'h11 * ((i % 4) + 1));
      want = {1'b1, c, d, 1'b0};
      n_checks++;
      if (d_pack() !== want) begin
        n_fail++;
        $display("FAIL auto_seq[%0d]: got %h expected %h", i, d_pack(), want);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] want;
    in_data = 32'h44332211; out_ready = 1; auto_en = 1;
    rst = 1;
    tick();
    rst = 0;
    tick();
    tick();
    out_ready = 0;
    in_data   = 32'hDDCCBBAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      want = {1'b1, 2'd1, 8'h22, 1'b0};
      n_checks++;
      if (d_pack() !== want) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h expected %h", i, d_pack(), want);
      end
    end
    out_ready = 1;
    tick();
    want = {1'b1, 2'd2, 8'hCC, 1'b0};
    n_checks++;
    if (d_pack() !== want) begin
      n_fail++;
      $display("FAIL stall_release: got %h expected %h", d_pack(), want);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      auto_en   = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      tick();
      n_checks++;
      if (d_pack() !== m_pack()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h expected %h", i, d_pack(), m_pack());
      end
    end
    rst = 0;
  endtask

  task automatic test_sel_err();
    logic [11:0] want;
    rst = 0; auto_en = 1; out_ready = 1;
    in_data3 = 24'h332211;
    sel3 = 2'd3;
    tick();
    want = {1'b1, 2'd3, 8'h00, 1'b1};
    n_checks++;
    if (d3_pack() !== want) begin
      n_fail++;
      $display("FAIL sel_err_set: got %h expected %h", d3_pack(), want);
    end
    sel3 = 2'd1;
    for (int i = 0; i < 2; i++) begin
      tick();
      want = {1'b1, 2'd1, 8'h22, 1'b1};
      n_checks++;
      if (d3_pack() !== want) begin
        n_fail++;
        $display("FAIL sel_err_sticky[%0d]: got %h expected %h", i, d3_pack(), want);
      end
    end
    rst = 1;
    tick();
    rst = 0;
    tick();
    want = {1'b1, 2'd1, 8'h22, 1'b0};
    n_checks++;
    if (d3_pack() !== want) begin
      n_fail++;
      $display("FAIL sel_err_cleared: got %h expected %h", d3_pack(), want);
    end
  endtask

`ifdef TDM_MUX_CHAN_MASK_EN
  task automatic test_mask();
    logic [11:0] want;
    logic [1:0]  c;
    in_data = 32'h44332211; out_ready = 1; auto_en = 1;
    rst = 1;
    tick();
    rst = 0;
    chan_mask = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      c    = (i % 2 == 0) ? 2'd1 : 2'd3;
      want = {1'b1, c, (i % 2 == 0) ? 8'h22 : 8'h44, 1'b0};
      n_checks++;
      if (d_pack() !== want) begin
        n_fail++;
        $display("FAIL mask_seq[%0d]: got %h expected %h", i, d_pack(), want);
      end
    end
    chan_mask = 4'b0000;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mask_empty_valid: got %b expected 0", out_valid);
    end
    auto_en = 0; sel = 2'd2; chan_mask = 4'b1011;
    tick();
    n_checks++;
    if (d_pack() !== m_pack()) begin
      n_fail++;
      $display("FAIL mask_manual_masked: got %h expected %h", d_pack(), m_pack());
    end
    chan_mask = 4'hF;
  endtask
`endif

  initial begin
    rst = 1; in_data = '0; sel = '0; auto_en = 0; out_ready = 1; chan_mask = 4'hF;
    in_data3 = 24'h332211; sel3 = '0;
    tick();
    tick();
    test_reset();
    test_manual();
    test_auto();
    test_backpressure();
    test_random();
    test_sel_err();
`ifdef TDM_MUX_CHAN_MASK_EN
    test_mask();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
